// File: rtl/set_key_ctrl.sv
// set_key_ctrl: synchronises and debounces the mode/adjust keys into clock field select and step pulses.
// Optional SET_AUTOREPEAT_EN adds auto-repeat of set_confirm while adjust is held.
module set_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100,
    parameter int CNT_W           = 10
) (
    input  logic       clk,
    input  logic       cr,
    input  logic       key_mode,
    input  logic       key_adjust,
    output logic [1:0] clock_set_select,
    output logic       set_confirm,
    output logic       set_active
);
    typedef enum logic [1:0] {RUN, SEC, MIN, HOUR} sel_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        DEBOUNCE_CYCLES >= 2**CNT_W || REPEAT_DELAY >= 2**CNT_W || REPEAT_PERIOD >= 2**CNT_W) begin : g_bad_param
        $error("set_key_ctrl: counter parameters out of range for CNT_W");
    end

    logic [1:0]       w_raw;
    logic [1:0]       r_sync0, r_sync1, r_db, r_db_d;
    logic [CNT_W-1:0] r_db_cnt [2];
    logic [1:0]       w_rise;
    logic             w_mode_rise, w_adj_rise, w_rep;
    sel_t             r_sel, w_sel_nxt;
    logic             r_active, r_confirm, w_active_nxt, w_confirm_nxt;

    assign w_raw = {key_adjust, key_mode};

    // Level flips only once the synchronised key has disagreed for DEBOUNCE_CYCLES+1 samples
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_sync0  <= '0;
            r_sync1  <= '0;
            r_db     <= '0;
            r_db_d   <= '0;
            r_db_cnt <= '{default: '0};
        end else begin
            r_sync0 <= w_raw;
            r_sync1 <= r_sync0;
            r_db_d  <= r_db;
            for (int k = 0; k < 2; k++) begin
                if (r_sync1[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] >= CNT_W'(DEBOUNCE_CYCLES)) begin
                    r_db[k]     <= ~r_db[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_rise      = r_db & ~r_db_d;
    assign w_mode_rise = w_rise[0];
    assign w_adj_rise  = w_rise[1];

`ifdef SET_AUTOREPEAT_EN
    logic             r_rep_arm, r_rep_first;
    logic [CNT_W-1:0] r_rep_cnt;

    assign w_rep = r_rep_arm & r_db[1] &
                   (r_rep_cnt == (r_rep_first ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1)));

    // Each emitted pulse restarts the interval; the press pulse selects the longer first delay
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_rep_arm   <= 1'b0;
            r_rep_first <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (w_mode_rise | ~r_db[1]) begin
            r_rep_arm <= 1'b0;
        end else if (w_confirm_nxt) begin
            r_rep_arm   <= 1'b1;
            r_rep_first <= w_adj_rise;
            r_rep_cnt   <= '0;
        end else if (r_rep_cnt != '1) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep = 1'b0;
`endif

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_sel     <= RUN;
            r_active  <= 1'b0;
            r_confirm <= 1'b0;
        end else begin
            r_sel     <= w_sel_nxt;
            r_active  <= w_active_nxt;
            r_confirm <= w_confirm_nxt;
        end
    end

    always_comb begin
        w_sel_nxt = w_mode_rise ? sel_t'(r_sel + 2'd1) : r_sel;
    end

    // A mode edge wins over a coincident adjust edge
    always_comb begin
        w_active_nxt  = w_sel_nxt != RUN;
        w_confirm_nxt = ~w_mode_rise & r_active & ~r_confirm & (w_adj_rise | w_rep);
    end

    assign clock_set_select = r_sel;
    assign set_active       = r_active;
    assign set_confirm      = r_confirm;
endmodule
